// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one shared 4-bit carry-lookahead slice.
// Operands in and results out over valid/ready; one nibble per clock, LSB first.

module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

module cla_nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic             cout_q;
  logic             ovf_q;

  logic [IdxW+1:0]  lo;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_cout;

  assign lo      = {idx_q, 2'b00};
  assign slice_a = a_q[lo +: 4];
  assign slice_b = b_q[lo +: 4];

  cla4_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[lo +: 4] <= slice_s;
          carry_q        <= slice_cout;
          if (idx_q == LastIdx) begin
            cout_q  <= slice_cout;
            // Carry into the MSB differs from carry out of it on signed overflow.
            ovf_q   <= slice_cout ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[3]);
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed and random checks of the nibble-serial adder against an integer-arithmetic model.

module tb_cla_nibble_serial_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic; overflow from the signed result range.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                       input logic msub, output logic [15:0] es, output logic ec,
                       output logic eo);
    int unsigned u;
    int          s;
    if (msub) begin
      u = int'(ma) + 32'h10000 - int'(mb);
      s = int'($signed(ma)) - int'($signed(mb));
    end else begin
      u = int'(ma) + int'(mb) + int'(mcin);
      s = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
    end
    es = u[15:0];
    ec = u[16];
    eo = (s > 32767) || (s < -32768);
  endtask

  // Wait for out_valid counting edges after the accept edge; expect exactly 4.
  task automatic wait_result(input string tag);
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 4);
  endtask

  task automatic check_result(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                              input logic tcin, input logic tsub);
    logic [15:0] es;
    logic        ec;
    logic        eo;
    model(ta, tb_, tcin, tsub, es, ec, eo);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(in_ready), 1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tcin, input logic tsub);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    wait_result(tag);
    check_result(tag, ta, tb_, tcin, tsub);
    drain(tag);
  endtask

  initial begin
    logic [15:0] hs;
    logic        hc;
    logic        ho;
    logic        seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases, with literal expectations for the key ones.
    run_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("addffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("sub3_5", 16'h0003, 16'h0005, 1'b1, 1'b1);
    run_op("sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1);

    // Absolute spot checks independent of the model.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("run_busy", 32'(busy), 1);
    chk("run_in_ready", 32'(in_ready), 0);
    wait_result("lit");
    chk("lit_sum", 32'(sum), 32'h8000);
    chk("lit_cout", 32'(cout), 0);
    chk("lit_ovf", 32'(overflow), 1);

    // Backpressure: new operands offered while DONE must not be captured.
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_sum", 32'(sum), 32'h8000);
      chk("bp_cout", 32'(cout), 0);
      chk("bp_ovf", 32'(overflow), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 1);
    chk("bp_idle_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy), 1);
    wait_result("bp_new");
    chk("bp_new_sum", 32'(sum), 32'h3334);
    check_result("bp_new", 16'h1111, 16'h2222, 1'b1, 1'b0);
    drain("bp_new");

    // Reset during the second RUN cycle aborts the op.
    a = 16'hABCD; b = 16'h1234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort_no_valid", 32'(seen), 0);
    run_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("post_abort_sum", 32'(sum), 32'h0002);

    // Random operations against the model.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i < 4) rb = ~ra;
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
    end

    model(16'h1234, 16'h4321, 1'b0, 1'b0, hs, hc, ho);
    chk("model_sanity", {15'd0, ho, hc, hs}, 32'h5555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
